// File: rtl/axis_packet_rr_arbiter.sv
// Packet-atomic round-robin arbiter merging CHANNEL_NUMBER AXI-Stream inputs onto one registered output.
// Define AXIS_ARB_PMU_EN to add per-channel saturating packet counters (pmu_clear_i, pmu_pkt_cnt_o).
//
// state | meaning
// IDLE  | no grant held; pick next requester after grant_q, wrapping modulo CHANNEL_NUMBER
// GRANT | channel grant_q owns the output until its TLAST beat is accepted
module axis_packet_rr_arbiter #(
  parameter int CHANNEL_NUMBER = 8,
  parameter int DATA_WIDTH     = 40,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] s_tdata_i,
  input  logic [CHANNEL_NUMBER-1:0]            s_tvalid_i,
  input  logic [CHANNEL_NUMBER-1:0]            s_tlast_i,
  output logic [CHANNEL_NUMBER-1:0]            s_tready_o,
  output logic [DATA_WIDTH-1:0]                m_tdata_o,
  output logic                                 m_tvalid_o,
  output logic                                 m_tlast_o,
  input  logic                                 m_tready_i,
  output logic [$clog2(CHANNEL_NUMBER)-1:0]    grant_o,
  output logic                                 busy_o
`ifdef AXIS_ARB_PMU_EN
  ,
  input  logic                                 pmu_clear_i,
  output logic [CHANNEL_NUMBER*CNT_WIDTH-1:0]  pmu_pkt_cnt_o
`endif
);

  localparam int GW = $clog2(CHANNEL_NUMBER);

  if (CHANNEL_NUMBER < 2 || CNT_WIDTH < 1) begin : g_param_check
    $error("axis_packet_rr_arbiter: CHANNEL_NUMBER must be >= 2 and CNT_WIDTH >= 1");
  end

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  busy_q, busy_d;
  logic [GW-1:0]         rr_idx, rr_sel;
  logic                  rr_found;
  logic                  slot_free, in_hs;

  assign slot_free = !tvalid_q || m_tready_i;
  assign in_hs     = (state_q == GRANT) && slot_free && s_tvalid_i[grant_q];

  // Search upward from the last grant so the previous winner ends up lowest priority.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = grant_q;
    rr_idx   = grant_q;
    for (int off = 1; off <= CHANNEL_NUMBER; off++) begin
      rr_idx = GW'((int'(grant_q) + off) % CHANNEL_NUMBER);
      if (!rr_found && s_tvalid_i[rr_idx]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
    end
  end

  always_comb begin
    s_tready_o = '0;
    if (state_q == GRANT) s_tready_o[grant_q] = slot_free;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    case (state_q)
      IDLE: begin
        if (slot_free) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
        if (rr_found) begin
          grant_d = rr_sel;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (in_hs) begin
          tdata_d  = s_tdata_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
          tlast_d  = s_tlast_i[grant_q];
          tvalid_d = 1'b1;
          if (s_tlast_i[grant_q]) state_d = IDLE;
        end else if (slot_free) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= IDLE;
      grant_q  <= GW'(CHANNEL_NUMBER - 1);
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
    end
  end

  assign m_tdata_o  = tdata_q;
  assign m_tvalid_o = tvalid_q;
  assign m_tlast_o  = tlast_q;
  assign grant_o    = grant_q;
  assign busy_o     = busy_q;

`ifdef AXIS_ARB_PMU_EN
  logic [CNT_WIDTH-1:0] cnt_q [CHANNEL_NUMBER];
  logic [CNT_WIDTH-1:0] cnt_d [CHANNEL_NUMBER];

  // Clear takes precedence over a same-cycle packet end.
  always_comb begin
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      cnt_d[i] = cnt_q[i];
      if (pmu_clear_i) begin
        cnt_d[i] = '0;
      end else if (in_hs && s_tlast_i[grant_q] && (grant_q == GW'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < CHANNEL_NUMBER; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNEL_NUMBER; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    pmu_pkt_cnt_o = '0;
    for (int i = 0; i < CHANNEL_NUMBER; i++) pmu_pkt_cnt_o[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end
`endif

endmodule

// File: doc/axis_packet_rr_arbiter.md
Name: axis_packet_rr_arbiter

Overview:
- Round-robin, packet-atomic arbiter that merges CHANNEL_NUMBER AXI-Stream channels onto one output link.
- Sits behind the per-channel stream FIFO buffer: each buffer output is one requester, and the arbiter drives the shared router or egress port.
- Once a channel is granted, it keeps the grant until its TLAST beat has been accepted. Packets are never interleaved.
- Output is registered: one register slice.

Parameters:
- CHANNEL_NUMBER, 8: number of input channels, ≥2.
- DATA_WIDTH, 40: TDATA width per channel.
- CNT_WIDTH, 16: width of per-channel packet counters. Used only with AXIS_ARB_PMU_EN.

Ports:
- ACLK  input  1  clock.
- ARESET  input  1  reset. One clock; reset is asynchronous and active-high.
- s_tdata_i  input  CHANNEL_NUMBER*DATA_WIDTH  input data; channel i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid_i  input  CHANNEL_NUMBER  per-channel TVALID.
- s_tlast_i  input  CHANNEL_NUMBER  per-channel TLAST.
- s_tready_o  output  CHANNEL_NUMBER  per-channel TREADY.
- m_tdata_o  output  DATA_WIDTH  merged data.
- m_tvalid_o  output  1  merged TVALID.
- m_tlast_o  output  1  merged TLAST.
- m_tready_i  input  1  downstream TREADY.
- grant_o  output  $clog2(CHANNEL_NUMBER)  index of the current or most recent grant.
- busy_o  output  1  1 while in GRANT state.

Behaviour:
- Reset values: s_tready_o=0, m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0, grant_o=CHANNEL_NUMBER-1 (so channel 0 wins first), busy_o=0, state=IDLE. Reset may be asserted mid-packet: the in-flight output beat is dropped and the next packet restarts from IDLE.
- Output slot is free when `!m_tvalid_o || m_tready_i`.
- State IDLE:
  - If any s_tvalid_i is set, select the first set bit searching upward from grant_o+1, modulo CHANNEL_NUMBER.
  - Register that index into grant_o and go to GRANT next cycle.
  - s_tready_o=0 throughout IDLE.
  - No requests: stay in IDLE; grant_o unchanged.
- State GRANT:
  - s_tready_o[g] = output slot free; all other bits are 0. Combinational from m_tready_i, no bubble.
  - Input beat transfer on channel g (s_tvalid_i[g] && s_tready_o[g]): load m_tdata_o and m_tlast_o, set m_tvalid_o=1 next cycle. Latency is 1 cycle input-to-output.
  - Slot free with no input beat: m_tvalid_o=0 next cycle.
  - TLAST transfer: return to IDLE next cycle, so there is exactly one idle input cycle between packets.
- Priority rotation: after a grant to channel k, channel k has the lowest priority at the next arbitration.
- Sustained throughput: 1 beat/cycle within a packet while m_tready_i=1. A stalled m_tready_i holds m_tdata_o, m_tvalid_o and m_tlast_o stable.
- AXIS compliance: m_tvalid_o never drops without a handshake. s_tvalid_i deasserting mid-packet (a bubble) keeps the grant.
- Wrap-around: search index arithmetic is modulo CHANNEL_NUMBER, including non-power-of-2 values.

Optional Feature:
- Macro AXIS_ARB_PMU_EN.
- Defined:
  - Adds input pmu_clear_i (1) and output pmu_pkt_cnt_o (CHANNEL_NUMBER*CNT_WIDTH).
  - Counter i increments on each TLAST transfer from channel i and saturates at all-ones.
  - pmu_clear_i=1 zeroes all counters synchronously and wins over a same-cycle increment.
  - ARESET zeroes all counters.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single channel 2 sends a 4-beat packet 0x10..0x13 with m_tready_i=1 → grant_o=2 one cycle after TVALID; output beats appear on 4 consecutive cycles, each 1 cycle after its input handshake; m_tlast_o on 0x13; busy_o falls after the last beat.
- All 8 channels hold 1-beat packets continuously → grant order 0,1,…,7,0; each channel gets 1 packet per 16 cycles.
- Channels 1 and 3 send 3-beat packets simultaneously → all 3 beats of channel 1 precede any beat of channel 3; no interleaving.
- m_tready_i held low for 5 cycles mid-packet → m_tdata_o and m_tlast_o stable; s_tready_o[g]=0; no beat lost or duplicated.
- ARESET pulsed while beat 2 of 4 is pending → all outputs return to reset values immediately; the next packet from channel 0 is forwarded cleanly.
- PMU (AXIS_ARB_PMU_EN, CNT_WIDTH=2): 5 packets on channel 4 → counter 4 reads 3 (saturated), others 0; pmu_clear_i → all 0.
